// File: rtl/mips32_pkg.sv
// Shared codes for the MIPS32 memory arbiter: FSM states, transaction owner, default widths.
package mips32_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_RD_WAIT = 1'b1} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} arb_owner_e;
endpackage

// File: rtl/mips32_arb_prio.sv
// DM-priority winner select with a saturating streak counter that hands IF
// one grant after MAX_DM_STREAK consecutive DM grants while IF waits.
module mips32_arb_prio
  import mips32_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  localparam int SW = $clog2(MAX_DM_STREAK + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dm_req,
  input  logic          if_vld,
  input  logic          accept,
  output arb_owner_e    winner,
  output logic [SW-1:0] streak
);
  logic streak_full;

  assign streak_full = (streak == SW'(MAX_DM_STREAK));
  assign winner      = (dm_req && !(if_vld && streak_full)) ? OWN_DM : OWN_IF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  streak <= '0;
    else if (!if_vld)                            streak <= '0;
    else if (accept && winner == OWN_IF)         streak <= '0;
    else if (accept && winner == OWN_DM && !streak_full) streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-outstanding arbiter between IF fetch and MEM-stage data ports onto one memory.
// Define MEM_ARB_STATS_EN to add stat_conflicts / stat_if_stall counters.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_conflicts,
  output logic [31:0]   stat_if_stall
`endif
);
  arb_state_e state, state_nxt;
  arb_owner_e owner, owner_nxt, winner;
  logic       drop, drop_nxt;
  logic       if_vld, idle, accept, sel_dm, rd_done;
  logic [$clog2(MAX_DM_STREAK+1)-1:0] streak;

  assign if_vld = if_req & ~halted;
  assign idle   = (state == ARB_IDLE);
  assign sel_dm = (winner == OWN_DM);

  mips32_arb_prio #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .dm_req (dm_req),
    .if_vld (if_vld),
    .accept (accept),
    .winner (winner),
    .streak (streak)
  );

  // Outputs are gated by rst_n so everything reads 0 while reset is held,
  // even if the pipeline keeps its requests asserted.
  assign mem_req   = rst_n & idle & (dm_req | if_vld);
  assign accept    = mem_req & mem_ready;
  assign mem_we    = mem_req & sel_dm & dm_we;
  assign mem_addr  = mem_req ? (sel_dm ? dm_addr : if_addr) : '0;
  assign mem_wdata = (mem_req & sel_dm) ? dm_wdata : '0;
  assign dm_gnt    = accept & sel_dm;
  assign if_gnt    = accept & ~sel_dm;

  // A flush arriving with the response itself must still suppress it.
  assign rd_done   = rst_n & (state == ARB_RD_WAIT) & mem_rvalid;
  assign if_rvalid = rd_done & (owner == OWN_IF) & ~drop & ~if_flush;
  assign dm_rvalid = rd_done & (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= OWN_IF;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      drop  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    drop_nxt  = drop;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          owner_nxt = winner;
          if (!(sel_dm && dm_we)) state_nxt = ARB_RD_WAIT;
          if (!sel_dm && if_flush) drop_nxt = 1'b1;
        end
      end
      ARB_RD_WAIT: begin
        if (owner == OWN_IF && if_flush) drop_nxt = 1'b1;
        if (mem_rvalid) begin
          state_nxt = ARB_IDLE;
          drop_nxt  = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
      stat_if_stall  <= '0;
    end else begin
      if (idle && dm_req && if_vld) stat_conflicts <= stat_conflicts + 32'd1;
      if (if_vld && !if_gnt)        stat_if_stall  <= stat_if_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter; memory handshake driven by hand from the stimulus.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0, rst_n = 1'b0, halted = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_if_stall;
`endif

  int total = 0;
  int bad   = 0;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_if_stall(stat_if_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq[6];
  int n;
  int exp_seq[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_gnt", {30'd0, if_gnt, dm_gnt}, 0);
    chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // lone IF read, response two cycles after accept
    if_req = 1; if_addr = 10'd5; mem_ready = 1; #1;
    chk("if1_gnt", 32'(if_gnt), 1);
    chk("if1_addr", 32'(mem_addr), 5);
    chk("if1_dm_gnt", 32'(dm_gnt), 0);
    tick(); if_req = 0; #1;
    chk("if1_rdwait_req", 32'(mem_req), 0);
    chk("if1_early_rvalid", 32'(if_rvalid), 0);
    tick(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("if1_rvalid", 32'(if_rvalid), 1);
    chk("if1_rdata", if_rdata, 32'hDEADBEEF);
    chk("if1_dm_rvalid", 32'(dm_rvalid), 0);
    tick(); mem_rvalid = 0;

    // DM load wins over simultaneous IF; IF follows after the load returns
    dm_req = 1; dm_we = 0; dm_addr = 10'd8; if_req = 1; if_addr = 10'd12; #1;
    chk("both_dm_gnt", 32'(dm_gnt), 1);
    chk("both_if_gnt", 32'(if_gnt), 0);
    chk("both_addr", 32'(mem_addr), 8);
    tick(); dm_req = 0; #1;
    chk("both_wait_if_gnt", 32'(if_gnt), 0);
    mem_rvalid = 1; mem_rdata = 32'hA5A5_0008; #1;
    chk("both_dm_rvalid", 32'(dm_rvalid), 1);
    chk("both_dm_rdata", dm_rdata, 32'hA5A5_0008);
    tick(); mem_rvalid = 0; #1;
    chk("both_if_gnt2", 32'(if_gnt), 1);
    chk("both_if_addr", 32'(mem_addr), 12);
    tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h77; #1;
    chk("both_if_rdata", if_rdata, 32'h77);
    tick(); mem_rvalid = 0;

    // store streak: expect DM,DM,DM,DM,IF,DM
    dm_req = 1; dm_we = 1; if_req = 1; if_addr = 10'd30; n = 0;
    for (int c = 0; c < 16 && n < 6; c++) begin
      dm_addr = 10'(40 + c); dm_wdata = 32'(c); #1;
      if (c == 0) chk("st_mem_we", 32'(mem_we), 1);
      if (dm_gnt) begin
        seq[n] = 1; n++;
      end else if (if_gnt) begin
        seq[n] = 0; n++;
        tick(); if_req = 0; #1;
        chk("streak_clr", 32'(dut.u_prio.streak), 0);
        mem_rvalid = 1; mem_rdata = 32'h30; #1;
        chk("st_if_rvalid", 32'(if_rvalid), 1);
      end
      tick(); mem_rvalid = 0;
    end
    chk("st_count", 32'(n), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("st_order%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    dm_req = 0; dm_we = 0; if_req = 0; tick();

    // flush one cycle after accept drops the response
    if_req = 1; if_addr = 10'd20; #1;
    chk("fl_gnt", 32'(if_gnt), 1);
    tick(); if_req = 0; if_flush = 1; #1;
    tick(); if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h1234; #1;
    chk("fl_dropped", 32'(if_rvalid), 0);
    tick(); mem_rvalid = 0;
    if_req = 1; if_addr = 10'd21; #1;
    chk("fl_next_gnt", 32'(if_gnt), 1);
    tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h55; #1;
    chk("fl_next_rvalid", 32'(if_rvalid), 1);
    chk("fl_next_rdata", if_rdata, 32'h55);
    tick(); mem_rvalid = 0;

    // flush in the same cycle as the response
    if_req = 1; if_addr = 10'd22; #1;
    tick(); if_req = 0; if_flush = 1; mem_rvalid = 1; mem_rdata = 32'h66; #1;
    chk("fl_same_cycle", 32'(if_rvalid), 0);
    tick(); if_flush = 0; mem_rvalid = 0;

    // halted masks IF, DM still served
    halted = 1; if_req = 1; #1;
    chk("halt_mem_req", 32'(mem_req), 0);
    chk("halt_if_gnt", 32'(if_gnt), 0);
    dm_req = 1; dm_we = 1; dm_addr = 10'd9; #1;
    chk("halt_dm_gnt", 32'(dm_gnt), 1);
    chk("halt_if_gnt2", 32'(if_gnt), 0);
    tick(); dm_req = 0; dm_we = 0; halted = 0; #1;

    // halted rising mid-read: read completes
    chk("hm_gnt", 32'(if_gnt), 1);
    tick(); if_req = 0; halted = 1; mem_rvalid = 1; mem_rdata = 32'hC0DE; #1;
    chk("hm_rdata", if_rdata, 32'hC0DE);
    tick(); mem_rvalid = 0; halted = 0;

    // memory not ready: request held, no grant
    if_req = 1; if_addr = 10'd7; mem_ready = 0; #1;
    chk("nr_req", 32'(mem_req), 1);
    chk("nr_gnt", 32'(if_gnt), 0);
    mem_ready = 1;

    // reset during RD_WAIT
    #1; tick(); mem_rvalid = 1; mem_rdata = 32'hFFFF; rst_n = 0; #1;
    chk("rrst_rvalid", 32'(if_rvalid), 0);
    chk("rrst_rdata", if_rdata, 0);
    chk("rrst_mem_req", 32'(mem_req), 0);
    chk("rrst_addr", 32'(mem_addr), 0);
    mem_rvalid = 0; #2; rst_n = 1; #1;
    chk("rrst_idle_gnt", 32'(if_gnt), 1);
    chk("rrst_idle_addr", 32'(mem_addr), 7);
    tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h99; #1;
    chk("rrst_rdata2", if_rdata, 32'h99);
    tick(); mem_rvalid = 0;

`ifdef MEM_ARB_STATS_EN
    rst_n = 0; #2; rst_n = 1; #1;
    chk("stat_rst", stat_conflicts, 0);
    dm_req = 1; dm_we = 1; if_req = 1; mem_ready = 0;
    tick(); tick(); tick();
    chk("stat_conflicts", stat_conflicts, 3);
    chk("stat_if_stall", stat_if_stall, 3);
    dm_req = 0; dm_we = 0; if_req = 0; tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
